// File: rtl/ramt_var_width_dp.sv
// True dual-port 32Kbit RAM with an independent power-of-two width per port,
// write-first read latches and an optional output register per port.
module ramt_var_width_dp #(
  parameter int REGISTERS_A = 0,
  parameter int REGISTERS_B = 0,
  parameter int LOG2WIDTH_A = 5,
  parameter int LOG2WIDTH_B = 5,
  parameter logic [255:0] INIT_00 = 256'h0, parameter logic [255:0] INIT_01 = 256'h0,
  parameter logic [255:0] INIT_02 = 256'h0, parameter logic [255:0] INIT_03 = 256'h0,
  parameter logic [255:0] INIT_04 = 256'h0, parameter logic [255:0] INIT_05 = 256'h0,
  parameter logic [255:0] INIT_06 = 256'h0, parameter logic [255:0] INIT_07 = 256'h0,
  parameter logic [255:0] INIT_08 = 256'h0, parameter logic [255:0] INIT_09 = 256'h0,
  parameter logic [255:0] INIT_0A = 256'h0, parameter logic [255:0] INIT_0B = 256'h0,
  parameter logic [255:0] INIT_0C = 256'h0, parameter logic [255:0] INIT_0D = 256'h0,
  parameter logic [255:0] INIT_0E = 256'h0, parameter logic [255:0] INIT_0F = 256'h0,
  parameter logic [255:0] INIT_10 = 256'h0, parameter logic [255:0] INIT_11 = 256'h0,
  parameter logic [255:0] INIT_12 = 256'h0, parameter logic [255:0] INIT_13 = 256'h0,
  parameter logic [255:0] INIT_14 = 256'h0, parameter logic [255:0] INIT_15 = 256'h0,
  parameter logic [255:0] INIT_16 = 256'h0, parameter logic [255:0] INIT_17 = 256'h0,
  parameter logic [255:0] INIT_18 = 256'h0, parameter logic [255:0] INIT_19 = 256'h0,
  parameter logic [255:0] INIT_1A = 256'h0, parameter logic [255:0] INIT_1B = 256'h0,
  parameter logic [255:0] INIT_1C = 256'h0, parameter logic [255:0] INIT_1D = 256'h0,
  parameter logic [255:0] INIT_1E = 256'h0, parameter logic [255:0] INIT_1F = 256'h0,
  parameter logic [255:0] INIT_20 = 256'h0, parameter logic [255:0] INIT_21 = 256'h0,
  parameter logic [255:0] INIT_22 = 256'h0, parameter logic [255:0] INIT_23 = 256'h0,
  parameter logic [255:0] INIT_24 = 256'h0, parameter logic [255:0] INIT_25 = 256'h0,
  parameter logic [255:0] INIT_26 = 256'h0, parameter logic [255:0] INIT_27 = 256'h0,
  parameter logic [255:0] INIT_28 = 256'h0, parameter logic [255:0] INIT_29 = 256'h0,
  parameter logic [255:0] INIT_2A = 256'h0, parameter logic [255:0] INIT_2B = 256'h0,
  parameter logic [255:0] INIT_2C = 256'h0, parameter logic [255:0] INIT_2D = 256'h0,
  parameter logic [255:0] INIT_2E = 256'h0, parameter logic [255:0] INIT_2F = 256'h0,
  parameter logic [255:0] INIT_30 = 256'h0, parameter logic [255:0] INIT_31 = 256'h0,
  parameter logic [255:0] INIT_32 = 256'h0, parameter logic [255:0] INIT_33 = 256'h0,
  parameter logic [255:0] INIT_34 = 256'h0, parameter logic [255:0] INIT_35 = 256'h0,
  parameter logic [255:0] INIT_36 = 256'h0, parameter logic [255:0] INIT_37 = 256'h0,
  parameter logic [255:0] INIT_38 = 256'h0, parameter logic [255:0] INIT_39 = 256'h0,
  parameter logic [255:0] INIT_3A = 256'h0, parameter logic [255:0] INIT_3B = 256'h0,
  parameter logic [255:0] INIT_3C = 256'h0, parameter logic [255:0] INIT_3D = 256'h0,
  parameter logic [255:0] INIT_3E = 256'h0, parameter logic [255:0] INIT_3F = 256'h0,
  parameter logic [255:0] INIT_40 = 256'h0, parameter logic [255:0] INIT_41 = 256'h0,
  parameter logic [255:0] INIT_42 = 256'h0, parameter logic [255:0] INIT_43 = 256'h0,
  parameter logic [255:0] INIT_44 = 256'h0, parameter logic [255:0] INIT_45 = 256'h0,
  parameter logic [255:0] INIT_46 = 256'h0, parameter logic [255:0] INIT_47 = 256'h0,
  parameter logic [255:0] INIT_48 = 256'h0, parameter logic [255:0] INIT_49 = 256'h0,
  parameter logic [255:0] INIT_4A = 256'h0, parameter logic [255:0] INIT_4B = 256'h0,
  parameter logic [255:0] INIT_4C = 256'h0, parameter logic [255:0] INIT_4D = 256'h0,
  parameter logic [255:0] INIT_4E = 256'h0, parameter logic [255:0] INIT_4F = 256'h0,
  parameter logic [255:0] INIT_50 = 256'h0, parameter logic [255:0] INIT_51 = 256'h0,
  parameter logic [255:0] INIT_52 = 256'h0, parameter logic [255:0] INIT_53 = 256'h0,
  parameter logic [255:0] INIT_54 = 256'h0, parameter logic [255:0] INIT_55 = 256'h0,
  parameter logic [255:0] INIT_56 = 256'h0, parameter logic [255:0] INIT_57 = 256'h0,
  parameter logic [255:0] INIT_58 = 256'h0, parameter logic [255:0] INIT_59 = 256'h0,
  parameter logic [255:0] INIT_5A = 256'h0, parameter logic [255:0] INIT_5B = 256'h0,
  parameter logic [255:0] INIT_5C = 256'h0, parameter logic [255:0] INIT_5D = 256'h0,
  parameter logic [255:0] INIT_5E = 256'h0, parameter logic [255:0] INIT_5F = 256'h0,
  parameter logic [255:0] INIT_60 = 256'h0, parameter logic [255:0] INIT_61 = 256'h0,
  parameter logic [255:0] INIT_62 = 256'h0, parameter logic [255:0] INIT_63 = 256'h0,
  parameter logic [255:0] INIT_64 = 256'h0, parameter logic [255:0] INIT_65 = 256'h0,
  parameter logic [255:0] INIT_66 = 256'h0, parameter logic [255:0] INIT_67 = 256'h0,
  parameter logic [255:0] INIT_68 = 256'h0, parameter logic [255:0] INIT_69 = 256'h0,
  parameter logic [255:0] INIT_6A = 256'h0, parameter logic [255:0] INIT_6B = 256'h0,
  parameter logic [255:0] INIT_6C = 256'h0, parameter logic [255:0] INIT_6D = 256'h0,
  parameter logic [255:0] INIT_6E = 256'h0, parameter logic [255:0] INIT_6F = 256'h0,
  parameter logic [255:0] INIT_70 = 256'h0, parameter logic [255:0] INIT_71 = 256'h0,
  parameter logic [255:0] INIT_72 = 256'h0, parameter logic [255:0] INIT_73 = 256'h0,
  parameter logic [255:0] INIT_74 = 256'h0, parameter logic [255:0] INIT_75 = 256'h0,
  parameter logic [255:0] INIT_76 = 256'h0, parameter logic [255:0] INIT_77 = 256'h0,
  parameter logic [255:0] INIT_78 = 256'h0, parameter logic [255:0] INIT_79 = 256'h0,
  parameter logic [255:0] INIT_7A = 256'h0, parameter logic [255:0] INIT_7B = 256'h0,
  parameter logic [255:0] INIT_7C = 256'h0, parameter logic [255:0] INIT_7D = 256'h0,
  parameter logic [255:0] INIT_7E = 256'h0, parameter logic [255:0] INIT_7F = 256'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [14-LOG2WIDTH_A:0]       addr_a,
  input  logic                          en_a,
  input  logic                          regen_a,
  input  logic                          we_a,
  input  logic [(1<<LOG2WIDTH_A)-1:0]   data_in_a,
  output logic [(1<<LOG2WIDTH_A)-1:0]   data_out_a,
  input  logic [14-LOG2WIDTH_B:0]       addr_b,
  input  logic                          en_b,
  input  logic                          regen_b,
  input  logic                          we_b,
  input  logic [(1<<LOG2WIDTH_B)-1:0]   data_in_b,
  output logic [(1<<LOG2WIDTH_B)-1:0]   data_out_b
);

  localparam int W_A = 1 << LOG2WIDTH_A;
  localparam int W_B = 1 << LOG2WIDTH_B;
  localparam logic [31:0] ONES_A = 32'hFFFF_FFFF >> (32 - W_A);
  localparam logic [31:0] ONES_B = 32'hFFFF_FFFF >> (32 - W_B);

  localparam logic [32767:0] INIT_ALL = {
    INIT_7F, INIT_7E, INIT_7D, INIT_7C, INIT_7B, INIT_7A, INIT_79, INIT_78,
    INIT_77, INIT_76, INIT_75, INIT_74, INIT_73, INIT_72, INIT_71, INIT_70,
    INIT_6F, INIT_6E, INIT_6D, INIT_6C, INIT_6B, INIT_6A, INIT_69, INIT_68,
    INIT_67, INIT_66, INIT_65, INIT_64, INIT_63, INIT_62, INIT_61, INIT_60,
    INIT_5F, INIT_5E, INIT_5D, INIT_5C, INIT_5B, INIT_5A, INIT_59, INIT_58,
    INIT_57, INIT_56, INIT_55, INIT_54, INIT_53, INIT_52, INIT_51, INIT_50,
    INIT_4F, INIT_4E, INIT_4D, INIT_4C, INIT_4B, INIT_4A, INIT_49, INIT_48,
    INIT_47, INIT_46, INIT_45, INIT_44, INIT_43, INIT_42, INIT_41, INIT_40,
    INIT_3F, INIT_3E, INIT_3D, INIT_3C, INIT_3B, INIT_3A, INIT_39, INIT_38,
    INIT_37, INIT_36, INIT_35, INIT_34, INIT_33, INIT_32, INIT_31, INIT_30,
    INIT_2F, INIT_2E, INIT_2D, INIT_2C, INIT_2B, INIT_2A, INIT_29, INIT_28,
    INIT_27, INIT_26, INIT_25, INIT_24, INIT_23, INIT_22, INIT_21, INIT_20,
    INIT_1F, INIT_1E, INIT_1D, INIT_1C, INIT_1B, INIT_1A, INIT_19, INIT_18,
    INIT_17, INIT_16, INIT_15, INIT_14, INIT_13, INIT_12, INIT_11, INIT_10,
    INIT_0F, INIT_0E, INIT_0D, INIT_0C, INIT_0B, INIT_0A, INIT_09, INIT_08,
    INIT_07, INIT_06, INIT_05, INIT_04, INIT_03, INIT_02, INIT_01, INIT_00
  };

  typedef logic [31:0] mem_t [1024];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < 1024; i++) m[i] = INIT_ALL[i*32 +: 32];
    return m;
  endfunction

  // Storage is kept as 1024 x 32-bit words; narrower ports are lanes within a word.
  mem_t mem_q = init_mem();

  logic [14:0]    pos_a, pos_b;
  logic [9:0]     word_a, word_b;
  logic [4:0]     off_a, off_b;
  logic [31:0]    mask_a, mask_b, wdat_a, wdat_b, new_a, new_b;
  logic [W_A-1:0] rd_a;
  logic [W_B-1:0] rd_b;
  logic           wr_a, wr_b, same_word;

  logic [W_A-1:0] lat_a_d, lat_a_q, out_a_d, out_a_q;
  logic [W_B-1:0] lat_b_d, lat_b_q, out_b_d, out_b_q;

  always_comb begin
    pos_a  = 15'(addr_a) << LOG2WIDTH_A;
    pos_b  = 15'(addr_b) << LOG2WIDTH_B;
    word_a = pos_a[14:5];
    word_b = pos_b[14:5];
    off_a  = pos_a[4:0];
    off_b  = pos_b[4:0];
    mask_a = ONES_A << off_a;
    mask_b = ONES_B << off_b;
    wdat_a = (32'(data_in_a) << off_a) & mask_a;
    wdat_b = (32'(data_in_b) << off_b) & mask_b;
    rd_a   = W_A'(mem_q[word_a] >> off_a);
    rd_b   = W_B'(mem_q[word_b] >> off_b);
    wr_a   = en_a & we_a;
    wr_b   = en_b & we_b;
    // Both ports hitting one word merge into a single update, B layered on top of A.
    same_word = wr_a & wr_b & (word_a == word_b);
    new_a  = (mem_q[word_a] & ~mask_a) | wdat_a;
    new_b  = ((same_word ? new_a : mem_q[word_b]) & ~mask_b) | wdat_b;
  end

  always_ff @(posedge clk) begin
    if (wr_a && !same_word) mem_q[word_a] <= new_a;
    if (wr_b)               mem_q[word_b] <= new_b;
  end

  always_comb begin
    lat_a_d = lat_a_q;
    out_a_d = out_a_q;
    lat_b_d = lat_b_q;
    out_b_d = out_b_q;
    if (!rst) begin
      lat_a_d = '0;
      out_a_d = '0;
      lat_b_d = '0;
      out_b_d = '0;
    end else begin
      if (en_a)    lat_a_d = we_a ? data_in_a : rd_a;
      if (regen_a) out_a_d = lat_a_q;
      if (en_b)    lat_b_d = we_b ? data_in_b : rd_b;
      if (regen_b) out_b_d = lat_b_q;
    end
  end

  always_ff @(posedge clk) begin
    lat_a_q <= lat_a_d;
    out_a_q <= out_a_d;
    lat_b_q <= lat_b_d;
    out_b_q <= out_b_d;
  end

  assign data_out_a = (REGISTERS_A != 0) ? out_a_q : lat_a_q;
  assign data_out_b = (REGISTERS_B != 0) ? out_b_q : lat_b_q;

endmodule

// File: tb/tb_ramt_var_width_dp.sv
// Scoreboard bench: port A 32-bit registered, port B 8-bit unregistered,
// checked cycle by cycle against a bit-level memory model.
module tb_ramt_var_width_dp;

  localparam int RA = 1;
  localparam int RB = 0;
  localparam int LA = 5;
  localparam int LB = 3;
  localparam logic [255:0] I00 = 256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01234567_89ABCDEF_12345678_0003ABCD;
  localparam logic [255:0] I01 = 256'hCAFEF00D_DEADC0DE_55AA55AA_00FF00FF_13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [255:0] I7F = 256'hA5A55A5A_11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr_a;
  logic        en_a, regen_a, we_a;
  logic [31:0] data_in_a, data_out_a;
  logic [11:0] addr_b;
  logic        en_b, regen_b, we_b;
  logic [7:0]  data_in_b, data_out_b;

  ramt_var_width_dp #(
    .REGISTERS_A(RA), .REGISTERS_B(RB), .LOG2WIDTH_A(LA), .LOG2WIDTH_B(LB),
    .INIT_00(I00), .INIT_01(I01), .INIT_7F(I7F)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .en_a(en_a), .regen_a(regen_a), .we_a(we_a),
    .data_in_a(data_in_a), .data_out_a(data_out_a),
    .addr_b(addr_b), .en_b(en_b), .regen_b(regen_b), .we_b(we_b),
    .data_in_b(data_in_b), .data_out_b(data_out_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] exp; string tag; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int    checks = 0;
  int    errors = 0;
  bit    stop = 0;
  string phase = "reset";

  // Reference model: flat bit memory plus the per-port read latch and output register.
  logic        rm [32768];
  logic [31:0] m_lat_a, m_out_a;
  logic [7:0]  m_lat_b, m_out_b;

  function automatic logic [31:0] mrd(int lg, int addr);
    logic [31:0] v = '0;
    int w = 1 << lg;
    for (int k = 0; k < w; k++) v[k] = rm[addr * w + k];
    return v;
  endfunction

  task automatic mwr(int lg, int addr, logic [31:0] d);
    int w = 1 << lg;
    for (int k = 0; k < w; k++) rm[addr * w + k] = d[k];
  endtask

  task automatic model_init();
    logic [255:0] t0, t1, t7;
    t0 = I00; t1 = I01; t7 = I7F;
    for (int k = 0; k < 32768; k++) rm[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      rm[k] = t0[k];
      rm[256 + k] = t1[k];
      rm[127*256 + k] = t7[k];
    end
    m_lat_a = '0; m_out_a = '0; m_lat_b = '0; m_out_b = '0;
  endtask

  task automatic model_step();
    logic [31:0] rda, rdb;
    exp_t e;
    rda = mrd(LA, int'(addr_a));
    rdb = mrd(LB, int'(addr_b));
    if (!rst) begin
      m_lat_a = '0; m_out_a = '0; m_lat_b = '0; m_out_b = '0;
    end else begin
      if (regen_a) m_out_a = m_lat_a;
      if (regen_b) m_out_b = m_lat_b;
      if (en_a) m_lat_a = we_a ? data_in_a : rda;
      if (en_b) m_lat_b = we_b ? data_in_b : rdb[7:0];
    end
    if (en_a && we_a) mwr(LA, int'(addr_a), data_in_a);
    if (en_b && we_b) mwr(LB, int'(addr_b), {24'h0, data_in_b});
    e.due = cyc + 1; e.tag = phase;
    e.exp = (RA != 0) ? m_out_a : m_lat_a;
    qa.push_back(e);
    e.exp = {24'h0, ((RB != 0) ? m_out_b : m_lat_b)};
    qb.push_back(e);
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        checks++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL %s A: entry due %0d not checked until cycle %0d", e.tag, e.due, cyc);
        end else if (data_out_a !== e.exp) begin
          errors++;
          $display("FAIL %s A cycle %0d: data_out_a=%08h expected %08h", e.tag, cyc, data_out_a, e.exp);
        end
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        checks++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL %s B: entry due %0d not checked until cycle %0d", e.tag, e.due, cyc);
        end else if (data_out_b !== e.exp[7:0]) begin
          errors++;
          $display("FAIL %s B cycle %0d: data_out_b=%02h expected %02h", e.tag, cyc, data_out_b, e.exp[7:0]);
        end
      end
      if (stop) begin
        while (qa.size() > 0) begin
          e = qa.pop_front(); checks++; errors++;
          $display("FAIL %s A: entry due %0d never presented", e.tag, e.due);
        end
        while (qb.size() > 0) begin
          e = qb.pop_front(); checks++; errors++;
          $display("FAIL %s B: entry due %0d never presented", e.tag, e.due);
        end
      end
    end
  end

  initial begin : driver
    model_init();
    rst = 1'b0;
    en_a = 1'b1; regen_a = 1'b1; we_a = 1'b0; addr_a = '0; data_in_a = '0;
    en_b = 1'b1; regen_b = 1'b1; we_b = 1'b0; addr_b = '0; data_in_b = '0;
    tick(2);

    phase = "init_read";
    rst = 1'b1; addr_a = 10'd0; addr_b = 12'd4;
    tick(3);
    addr_a = 10'd1; addr_b = 12'd5;
    tick(3);

    phase = "write_first";
    addr_a = 10'd5; data_in_a = 32'hDEADBEEF; we_a = 1'b1;
    tick(1);
    we_a = 1'b0;
    tick(3);

    phase = "mixed_width";
    addr_a = 10'd2; data_in_a = 32'hAABBCCDD; we_a = 1'b1;
    tick(1);
    we_a = 1'b0;
    for (int m = 8; m < 12; m++) begin
      addr_b = 12'(m);
      tick(1);
    end
    addr_b = 12'd9; data_in_b = 8'h11; we_b = 1'b1;
    tick(1);
    we_b = 1'b0;
    tick(3);

    phase = "reset_hold";
    addr_a = 10'd2; addr_b = 12'd11;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);

    phase = "regen_hold";
    regen_a = 1'b0; addr_a = 10'd5;
    tick(3);
    regen_a = 1'b1;
    tick(2);
    phase = "en_hold";
    en_a = 1'b0; en_b = 1'b0; addr_a = 10'd2; addr_b = 12'd0;
    tick(3);
    en_a = 1'b1; en_b = 1'b1;
    tick(2);

    phase = "dual_write";
    addr_a = 10'd3; data_in_a = 32'h01020304; we_a = 1'b1;
    addr_b = 12'd13; data_in_b = 8'hEE; we_b = 1'b1;
    tick(1);
    we_a = 1'b0; we_b = 1'b0;
    tick(3);
    phase = "read_during_write";
    addr_a = 10'd4; addr_b = 12'd16; data_in_b = 8'h5C; we_b = 1'b1;
    tick(1);
    we_b = 1'b0;
    tick(3);

    phase = "top_word";
    addr_a = 10'd1023; addr_b = 12'd4095;
    tick(3);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 31) != 0);
      en_a      = ($urandom_range(0, 7) != 0);
      en_b      = ($urandom_range(0, 7) != 0);
      regen_a   = ($urandom_range(0, 3) != 0);
      regen_b   = ($urandom_range(0, 3) != 0);
      we_a      = ($urandom_range(0, 3) == 0);
      we_b      = ($urandom_range(0, 3) == 0);
      addr_a    = $urandom_range(0, 1) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(0, 1023));
      addr_b    = $urandom_range(0, 1) ? 12'($urandom_range(0, 31)) : 12'($urandom_range(0, 4095));
      data_in_a = $urandom;
      data_in_b = 8'($urandom);
      tick(1);
    end

    stop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
